tt_schedule_sequencer: RTL and testbench

Schedule-table sequencer for the time-triggered transmit path. Holds a programmable list of up to DEPTH transmit slots, presents one slot at a time on the `schedule` word consumed by the GTB comparator, and advances on the comparator's `tx` pulse. It repeats the list every `cfg_period` GTB ticks and flags any slot whose time passed without a fire.

---
 rtl/tt_pkg.sv | 20 ++
 rtl/tt_sched_table.sv | 30 +++
 rtl/tt_schedule_sequencer.sv | 141 ++++++++++++++
 tb/tb_tt_schedule_sequencer.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tt_pkg.sv
// Shared constants and types for the time-triggered schedule sequencer.
// Field positions follow the {port, offset} table entry layout.
package tt_pkg;

   localparam int TW       = 29;
   localparam int PW       = 3;
   localparam int PORT_MSB = 31;
   localparam int PORT_LSB = 29;
   localparam int OFS_MSB  = 28;

   localparam logic [TW-1:0] LATE_MIN = 29'd2;
   localparam logic [TW-1:0] LATE_MAX = 29'h1000_0000;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ARM  = 2'd1,
      WAIT = 2'd2
   } state_t;

endpackage

// File: rtl/tt_sched_table.sv
// DEPTH x 32 schedule register file.
// Synchronous write, asynchronous read, cleared by reset.
module tt_sched_table #(
   parameter int DEPTH = 8,
   parameter int AW    = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [31:0]   wdata,
   input  logic [AW-1:0] raddr,
   output logic [31:0]   rdata
);

   logic [31:0] mem [DEPTH];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/tt_schedule_sequencer.sv
// Time-triggered transmit schedule sequencer: walks the slot table,
// presents {port, abs_time} to the comparator and flags missed slots.
module tt_schedule_sequencer
   import tt_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int AW    = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [31:0]   GTB,
   input  logic          enable,
   input  logic          cfg_we,
   input  logic [AW-1:0] cfg_addr,
   input  logic [31:0]   cfg_data,
   input  logic [AW:0]   cfg_len,
   input  logic [TW-1:0] cfg_period,
   input  logic [TW-1:0] cfg_base,
   input  logic          fire,
   output logic [31:0]   schedule,
   output logic [AW-1:0] idx,
   output logic [15:0]   cycle_cnt,
   output logic          late,
   output logic          busy,
   output logic          cfg_err
);

   state_t        state;
   state_t        nstate;
   logic [AW:0]   len;
   logic [TW-1:0] period;
   logic [TW-1:0] cycle_base;
   logic [31:0]   entry;
   logic [TW-1:0] abs_t;
   logic [TW-1:0] d;
   logic          in_win;
   logic          adv;
   logic          last;
   logic          len_ok;
   logic          start;
   logic          tbl_we;
   logic          late_d;
   logic          err_d;
   logic          gtb_unused;

   assign gtb_unused = ^GTB[31:TW];

   tt_sched_table #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_table (
      .clk   (clk),
      .rst   (rst),
      .we    (tbl_we),
      .waddr (cfg_addr),
      .wdata (cfg_data),
      .raddr (idx),
      .rdata (entry)
   );

   assign tbl_we = cfg_we && (state == IDLE);
   assign abs_t  = cycle_base + entry[OFS_MSB:0];

   // d == 1 is the normal fire, so the late window opens at 2
   assign d      = GTB[TW-1:0] - schedule[TW-1:0];
   assign in_win = (d >= LATE_MIN) && (d < LATE_MAX);
   assign adv    = (state == WAIT) && (fire || in_win);
   assign last   = (idx == AW'(len - 1'b1));
   assign len_ok = (cfg_len != '0) && (cfg_len <= (AW+1)'(DEPTH));
   assign start  = (state == IDLE) && enable && len_ok;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= nstate;
      end
   end

   always_comb begin
      nstate = state;
      unique case (1'b1)
         state == IDLE: begin
            if (start) nstate = ARM;
         end
         state == ARM: begin
            nstate = WAIT;
         end
         state == WAIT: begin
            if (adv) nstate = enable ? ARM : IDLE;
            else if (!enable) nstate = IDLE;
         end
         default: nstate = IDLE;
      endcase
   end

   always_comb begin
      busy   = (state != IDLE);
      late_d = (state == WAIT) && !fire && in_win;
      err_d  = ((state == IDLE) && enable && !len_ok)
             || ((state != IDLE) && cfg_we);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         schedule   <= '0;
         idx        <= '0;
         cycle_cnt  <= '0;
         cycle_base <= '0;
         len        <= '0;
         period     <= '0;
         late       <= 1'b0;
         cfg_err    <= 1'b0;
      end else begin
         late    <= late_d;
         cfg_err <= err_d;
         if (start) begin
            len        <= cfg_len;
            period     <= cfg_period;
            cycle_base <= cfg_base;
            idx        <= '0;
         end
         if (state == ARM) begin
            schedule <= {entry[PORT_MSB:PORT_LSB], abs_t};
         end
         if (adv) begin
            if (last) begin
               idx        <= '0;
               cycle_base <= cycle_base + period;
               cycle_cnt  <= cycle_cnt + 16'd1;
            end else begin
               idx <= idx + 1'b1;
            end
         end
         if ((state != IDLE) && (nstate == IDLE)) begin
            schedule <= '0;
         end
      end
   end

endmodule

// File: tb/tb_tt_schedule_sequencer.sv
// Directed bench for tt_schedule_sequencer with a behavioural
// GTB counter and comparator closing the loop.
module tb_tt_schedule_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] gtb = '0;
   logic        gtb_load;
   logic [31:0] gtb_val;
   logic        enable;
   logic        cfg_we;
   logic [2:0]  cfg_addr;
   logic [31:0] cfg_data;
   logic [3:0]  cfg_len;
   logic [28:0] cfg_period;
   logic [28:0] cfg_base;
   logic        fire = 1'b0;
   logic [31:0] schedule;
   logic [2:0]  idx;
   logic [15:0] cycle_cnt;
   logic        late;
   logic        busy;
   logic        cfg_err;

   int errors = 0;
   int checks = 0;
   int late_seen = 0;
   int late0;
   bit hit;

   tt_schedule_sequencer dut (
      .clk        (clk),
      .rst        (rst),
      .GTB        (gtb),
      .enable     (enable),
      .cfg_we     (cfg_we),
      .cfg_addr   (cfg_addr),
      .cfg_data   (cfg_data),
      .cfg_len    (cfg_len),
      .cfg_period (cfg_period),
      .cfg_base   (cfg_base),
      .fire       (fire),
      .schedule   (schedule),
      .idx        (idx),
      .cycle_cnt  (cycle_cnt),
      .late       (late),
      .busy       (busy),
      .cfg_err    (cfg_err)
   );

   always #5 clk = ~clk;

   // comparator: tx one cycle after GTB == schedule
   always @(posedge clk) begin
      gtb  <= gtb_load ? gtb_val : gtb + 32'd1;
      fire <= (gtb[28:0] == schedule[28:0]);
      if (late === 1'b1) late_seen <= late_seen + 1;
   end

   function automatic logic [31:0] mk(input logic [2:0] p,
                                      input logic [28:0] t);
      return {p, t};
   endfunction

   task automatic tick;
      @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [2:0] a, input logic [31:0] v);
      cfg_we   = 1'b1;
      cfg_addr = a;
      cfg_data = v;
      tick();
      cfg_we   = 1'b0;
   endtask

   task automatic load_gtb(input logic [31:0] v);
      gtb_load = 1'b1;
      gtb_val  = v;
      tick();
      gtb_load = 1'b0;
   endtask

   task automatic wait_sched(input string tag, input logic [31:0] exp,
                             input int budget);
      for (int i = 0; i < budget; i++) begin
         if (schedule === exp) break;
         tick();
      end
      check(tag, schedule, exp);
   endtask

   initial begin
      rst = 1'b1;
      gtb_load = 1'b0;
      gtb_val = '0;
      enable = 1'b0;
      cfg_we = 1'b0;
      cfg_addr = '0;
      cfg_data = '0;
      cfg_len = '0;
      cfg_period = '0;
      cfg_base = '0;
      tick();
      tick();
      check("rst_sched", schedule, 32'd0);
      check("rst_idx", 32'(idx), 32'd0);
      check("rst_cnt", 32'(cycle_cnt), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_late", 32'(late), 32'd0);
      check("rst_err", 32'(cfg_err), 32'd0);
      rst = 1'b0;
      tick();

      // illegal lengths
      cfg_len = 4'd0;
      enable = 1'b1;
      tick();
      check("len0_err", 32'(cfg_err), 32'd1);
      check("len0_busy", 32'(busy), 32'd0);
      enable = 1'b0;
      tick();
      check("len0_err_clr", 32'(cfg_err), 32'd0);
      check("len0_idle", 32'(busy), 32'd0);
      cfg_len = 4'd9;
      enable = 1'b1;
      tick();
      check("len9_err", 32'(cfg_err), 32'd1);
      check("len9_busy", 32'(busy), 32'd0);
      enable = 1'b0;
      tick();

      // basic two-slot schedule
      cfg_len = 4'd2;
      cfg_period = 29'd1000;
      cfg_base = 29'd100;
      wr(3'd0, mk(3'd5, 29'd10));
      wr(3'd1, mk(3'd2, 29'd40));
      load_gtb(32'd0);
      late0 = late_seen;
      enable = 1'b1;
      tick();
      check("t1_busy", 32'(busy), 32'd1);
      wait_sched("t1_s0", mk(3'd5, 29'd110), 20);
      check("t1_idx0", 32'(idx), 32'd0);
      wait_sched("t1_s1", mk(3'd2, 29'd140), 200);
      check("t1_idx1", 32'(idx), 32'd1);
      wait_sched("t1_s2", mk(3'd5, 29'd1110), 200);
      check("t1_cnt1", 32'(cycle_cnt), 32'd1);
      wait_sched("t1_s3", mk(3'd2, 29'd1140), 1200);
      wait_sched("t1_s4", mk(3'd5, 29'd2110), 200);
      check("t1_cnt2", 32'(cycle_cnt), 32'd2);
      check("t1_nolate", 32'(late_seen - late0), 32'd0);

      // drop enable together with fire
      hit = 1'b0;
      for (int i = 0; i < 1500; i++) begin
         if (fire === 1'b1) begin
            hit = 1'b1;
            enable = 1'b0;
            break;
         end
         tick();
      end
      check("t5_fire_seen", 32'(hit), 32'd1);
      tick();
      check("t5_idle", 32'(busy), 32'd0);
      check("t5_sched0", schedule, 32'd0);
      check("t5_idx", 32'(idx), 32'd1);
      load_gtb(32'd50);
      enable = 1'b1;
      wait_sched("t5_restart", mk(3'd5, 29'd110), 20);
      check("t5_idx0", 32'(idx), 32'd0);
      enable = 1'b0;
      tick();
      tick();

      // enable after the first slot has already passed
      load_gtb(32'd118);
      late0 = late_seen;
      enable = 1'b1;
      wait_sched("t2_s1", mk(3'd2, 29'd140), 20);
      check("t2_idx1", 32'(idx), 32'd1);
      check("t2_late1", 32'(late_seen - late0), 32'd1);
      wait_sched("t2_s2", mk(3'd5, 29'd1110), 200);
      check("t2_late_once", 32'(late_seen - late0), 32'd1);
      enable = 1'b0;
      tick();
      tick();

      // cycle_base wrap across 2^29
      cfg_len = 4'd1;
      cfg_period = 29'd16;
      cfg_base = 29'h1FFF_FFFB;
      wr(3'd0, mk(3'd3, 29'd10));
      load_gtb(32'h1FFF_FFF0);
      late0 = late_seen;
      enable = 1'b1;
      wait_sched("t3_s0", mk(3'd3, 29'd5), 20);
      wait_sched("t3_s1", mk(3'd3, 29'd21), 60);
      check("t3_nolate", 32'(late_seen - late0), 32'd0);

      // write while busy is dropped
      cfg_we = 1'b1;
      cfg_addr = 3'd0;
      cfg_data = 32'hFFFF_FFFF;
      tick();
      cfg_we = 1'b0;
      check("t4_we_err", 32'(cfg_err), 32'd1);
      tick();
      check("t4_err_clr", 32'(cfg_err), 32'd0);
      wait_sched("t4_tbl_kept", mk(3'd3, 29'd37), 60);

      // asynchronous reset mid-WAIT
      #2;
      rst = 1'b1;
      #1;
      check("t6_sched", schedule, 32'd0);
      check("t6_idx", 32'(idx), 32'd0);
      check("t6_cnt", 32'(cycle_cnt), 32'd0);
      check("t6_late", 32'(late), 32'd0);
      check("t6_busy", 32'(busy), 32'd0);
      check("t6_err", 32'(cfg_err), 32'd0);
      tick();
      rst = 1'b0;
      cfg_base = 29'd100;
      cfg_period = 29'd1000;
      load_gtb(32'd10);
      enable = 1'b1;
      tick();
      tick();
      tick();
      check("t6_tbl_clr", schedule, mk(3'd0, 29'd100));
      enable = 1'b0;
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
